led_pattern_engine: RTL and testbench



---
 rtl/led_pkg.sv | 24 ++
 rtl/led_pattern_engine_if.sv | 26 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_pattern_engine.sv | 126 ++++++++++++
 tb/tb_led_pattern_engine.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared mode codes, direction encoding and status-word bit positions
// for the LED pattern engine.
package led_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned SPEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int unsigned ST_MODE_LSB  = 0;
  localparam int unsigned ST_PAUSE_BIT = 2;
  localparam int unsigned ST_DIR_BIT   = 3;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Config/control inputs and LED outputs of the pattern engine, bundled as one bus.
interface led_pattern_engine_if
  import led_pkg::*;
#(
  parameter int unsigned W = 8
);
  logic [MODE_W-1:0]  cfg_mode;
  logic [SPEED_W-1:0] cfg_speed;
  logic               cfg_load;
  logic               pause;
  logic               step;
  logic [W-1:0]       led_display;
  logic [W-1:0]       debug_led;
  logic [W-1:0]       status_led;
  logic               tick;

  modport master (
    output cfg_mode, cfg_speed, cfg_load, pause, step,
    input  led_display, debug_led, status_led, tick
  );

  modport slave (
    input  cfg_mode, cfg_speed, cfg_load, pause, step,
    output led_display, debug_led, status_led, tick
  );
endinterface

// File: rtl/led_tick_gen.sv
// Programmable step-event generator: free-running divider with pause hold
// and manual single-step while paused.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               step,
  input  logic               clr,
  output logic               step_evt
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] last_c;

  // Terminal count for the active speed; the >= guard keeps a stale count safe.
  always_comb begin
    last_c = CW'((TICK_DIV >> speed) - 32'd1);
  end

  assign step_evt = pause ? step : (cnt >= last_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt >= last_c) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Running-light pattern engine: one pattern register stepped through four modes,
// with double-buffered config that takes effect on the next step.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter logic [W-1:0] INIT_PATTERN = W'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pattern_engine_if.slave  bus
);

  logic [W-1:0]       pattern;
  logic [W-1:0]       next_pattern_c;
  dir_e               dir;
  dir_e               next_dir_c;
  mode_e              mode;
  mode_e              pend_mode;
  logic [SPEED_W-1:0] speed;
  logic [SPEED_W-1:0] pend_speed;
  logic               pend_valid;
  logic               step_evt;
  logic               apply_c;
  logic               restart_c;
  logic [W-1:0]       status_c;
  logic [W-1:0]       rst_status_c;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .speed    (speed),
    .pause    (bus.pause),
    .step     (bus.step),
    .clr      (apply_c),
    .step_evt (step_evt)
  );

  // Pattern advance under the currently active mode.
  always_comb begin
    next_pattern_c = pattern;
    next_dir_c     = dir;
    case (mode)
      MODE_ROTL: next_pattern_c = {pattern[W-2:0], pattern[W-1]};
      MODE_ROTR: next_pattern_c = {pattern[0], pattern[W-1:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          if (pattern[W-1]) begin
            next_dir_c     = DIR_RIGHT;
            next_pattern_c = pattern >> 1;
          end else begin
            next_pattern_c = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            next_dir_c     = DIR_LEFT;
            next_pattern_c = pattern << 1;
          end else begin
            next_pattern_c = pattern >> 1;
          end
        end
      end
      MODE_BLINK: next_pattern_c = ~pattern;
      default: ;
    endcase
  end

  always_comb begin
    apply_c   = step_evt & pend_valid;
    restart_c = apply_c && (pend_mode == MODE_BOUNCE) && (mode != MODE_BOUNCE);
  end

  always_comb begin
    status_c                           = '0;
    status_c[ST_MODE_LSB +: MODE_W]    = mode;
    status_c[ST_PAUSE_BIT]             = bus.pause;
    status_c[ST_DIR_BIT]               = dir;
    rst_status_c                       = '0;
    rst_status_c[ST_PAUSE_BIT]         = bus.pause;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern         <= INIT_PATTERN;
      dir             <= DIR_LEFT;
      mode            <= MODE_ROTL;
      speed           <= '0;
      pend_mode       <= MODE_ROTL;
      pend_speed      <= '0;
      pend_valid      <= 1'b0;
      bus.led_display <= '0;
      bus.debug_led   <= '0;
      bus.tick        <= 1'b0;
      bus.status_led  <= rst_status_c;
    end else begin
      bus.tick       <= step_evt;
      bus.status_led <= status_c;
      if (step_evt) begin
        bus.led_display <= pattern;
        bus.debug_led   <= ~pattern;
        pattern         <= next_pattern_c;
        dir             <= next_dir_c;
      end
      if (apply_c) begin
        mode       <= pend_mode;
        speed      <= pend_speed;
        pend_valid <= 1'b0;
      end
      // Entering BOUNCE restarts from a single lit LED moving left.
      if (restart_c) begin
        pattern <= W'(1);
        dir     <= DIR_LEFT;
      end
      // A load on the apply edge is kept for the following step.
      if (bus.cfg_load) begin
        pend_mode  <= mode_e'(bus.cfg_mode);
        pend_speed <= bus.cfg_speed;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: two instances (TICK_DIV 4 and 8) sharing clk/rst.
module tb_led_pattern_engine;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  led_pattern_engine_if #(.W(8)) if4 ();
  led_pattern_engine_if #(.W(8)) if8 ();

  led_pattern_engine #(.W(8), .TICK_DIV(4), .INIT_PATTERN(8'h01)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );
  led_pattern_engine #(.W(8), .TICK_DIV(8), .INIT_PATTERN(8'h01)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] p);
    return {p[6:0], p[7]};
  endfunction

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the selected instance pulses tick or the budget expires.
  task automatic wait_tick(input int sel, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      ok = (sel == 0) ? if4.tick : if8.tick;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.pause = 1'b1;
    cyc(1);
    checks++;
    if (if4.status_led !== 8'h04) begin
      errors++; $display("FAIL rst_status_pause: got %h expected %h", if4.status_led, 8'h04);
    end
    if4.pause = 1'b0;
    cyc(1);
    checks++;
    if (if4.led_display !== 8'h00 || if4.debug_led !== 8'h00 || if4.tick !== 1'b0) begin
      errors++; $display("FAIL rst_out4: got led=%h dbg=%h tick=%b expected 00 00 0",
                         if4.led_display, if4.debug_led, if4.tick);
    end
    checks++;
    if (if4.status_led !== 8'h00) begin
      errors++; $display("FAIL rst_status4: got %h expected 00", if4.status_led);
    end
    checks++;
    if (if8.led_display !== 8'h00 || if8.debug_led !== 8'h00 || if8.status_led !== 8'h00) begin
      errors++; $display("FAIL rst_out8: got led=%h dbg=%h st=%h expected 00 00 00",
                         if8.led_display, if8.debug_led, if8.status_led);
    end
  endtask

  task automatic test_rotl();
    logic [7:0] seq [10];
    int k;
    int gap;
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    k   = 0;
    gap = 0;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      gap++;
      if (if4.tick === 1'b1) begin
        if (k < 10) begin
          checks++;
          if (if4.led_display !== seq[k] || if4.debug_led !== ~seq[k]) begin
            errors++; $display("FAIL rotl_step%0d: got led=%h dbg=%h expected %h %h",
                               k, if4.led_display, if4.debug_led, seq[k], ~seq[k]);
          end
        end
        checks++;
        if (gap !== 4) begin
          errors++; $display("FAIL rotl_period%0d: got %0d expected 4", k, gap);
        end
        k++;
        gap = 0;
      end else if (k == 0) begin
        checks++;
        if (if4.led_display !== 8'h00 || if4.debug_led !== 8'h00) begin
          errors++; $display("FAIL rotl_pre_tick: got led=%h dbg=%h expected 00 00",
                             if4.led_display, if4.debug_led);
        end
      end
    end
    checks++;
    if (k !== 10) begin
      errors++; $display("FAIL rotl_tick_count: got %0d expected 10", k);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_led [17];
    bit         exp_dir [17];
    int n;
    bit ok;
    bit found;
    exp_led = '{8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    exp_dir = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      wait_tick(0, 8, n, ok);
      found = ok && (if4.led_display === 8'h08);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL bounce_sync: got no tick showing %h expected one", 8'h08);
    end
    if4.cfg_mode = 2'd2;
    if4.cfg_load = 1'b1;
    cyc(1);
    if4.cfg_load = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wait_tick(0, 8, n, ok);
      checks++;
      if (!ok || if4.led_display !== exp_led[i]) begin
        errors++; $display("FAIL bounce_led%0d: got tick=%b led=%h expected 1 %h",
                           i, ok, if4.led_display, exp_led[i]);
      end
      cyc(1);
      checks++;
      if (if4.status_led !== {4'b0, exp_dir[i], 1'b0, 2'b10}) begin
        errors++; $display("FAIL bounce_status%0d: got %h expected %h",
                           i, if4.status_led, {4'b0, exp_dir[i], 1'b0, 2'b10});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [4];
    int n;
    bit ok;
    seq = '{8'h01, 8'h02, 8'h04, 8'h08};
    if4.cfg_mode = 2'd3;
    if4.cfg_load = 1'b1;
    cyc(1);
    if4.cfg_load = 1'b0;
    rst = 1'b1;
    cyc(1);
    checks++;
    if (if4.led_display !== 8'h00 || if4.debug_led !== 8'h00 ||
        if4.tick !== 1'b0 || if4.status_led !== 8'h00) begin
      errors++; $display("FAIL midrst_out: got led=%h dbg=%h tick=%b st=%h expected 00 00 0 00",
                         if4.led_display, if4.debug_led, if4.tick, if4.status_led);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(0, 8, n, ok);
      checks++;
      if (!ok || if4.led_display !== seq[i] || (i == 0 && n !== 4)) begin
        errors++; $display("FAIL midrst_step%0d: got tick=%b led=%h wait=%0d expected 1 %h 4",
                           i, ok, if4.led_display, n, seq[i]);
      end
    end
    cyc(1);
    checks++;
    if (if4.status_led !== 8'h00) begin
      errors++; $display("FAIL midrst_status: got %h expected 00", if4.status_led);
    end
  endtask

  task automatic test_pause();
    int ticks;
    int n;
    bit ok;
    if4.pause = 1'b1;
    cyc(1);
    checks++;
    if (if4.status_led !== 8'h04 || if4.tick !== 1'b0) begin
      errors++; $display("FAIL pause_status: got st=%h tick=%b expected 04 0", if4.status_led, if4.tick);
    end
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (if4.tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0 || if4.led_display !== 8'h08 || if4.debug_led !== 8'hF7) begin
      errors++; $display("FAIL pause_frozen: got ticks=%0d led=%h dbg=%h expected 0 08 f7",
                         ticks, if4.led_display, if4.debug_led);
    end
    if4.step = 1'b1;
    cyc(1);
    if4.step = 1'b0;
    checks++;
    if (if4.tick !== 1'b1 || if4.led_display !== 8'h10 || if4.debug_led !== 8'hEF) begin
      errors++; $display("FAIL pause_step1: got tick=%b led=%h dbg=%h expected 1 10 ef",
                         if4.tick, if4.led_display, if4.debug_led);
    end
    cyc(1);
    checks++;
    if (if4.tick !== 1'b0) begin
      errors++; $display("FAIL pause_tick_width: got %b expected 0", if4.tick);
    end
    cyc(2);
    if4.step = 1'b1;
    cyc(1);
    if4.step = 1'b0;
    checks++;
    if (if4.tick !== 1'b1 || if4.led_display !== 8'h20) begin
      errors++; $display("FAIL pause_step2: got tick=%b led=%h expected 1 20", if4.tick, if4.led_display);
    end
    if4.pause = 1'b0;
    if4.step  = 1'b1;
    cyc(1);
    if4.step  = 1'b0;
    checks++;
    if (if4.tick !== 1'b0 || if4.led_display !== 8'h20) begin
      errors++; $display("FAIL step_unpaused: got tick=%b led=%h expected 0 20", if4.tick, if4.led_display);
    end
    wait_tick(0, 8, n, ok);
    checks++;
    if (!ok || n !== 2 || if4.led_display !== 8'h40) begin
      errors++; $display("FAIL pause_resume: got tick=%b wait=%0d led=%h expected 1 2 40",
                         ok, n, if4.led_display);
    end
  endtask

  task automatic test_blink();
    logic [7:0] seq [5];
    int n;
    bit ok;
    seq = '{8'h80, 8'h01, 8'hFE, 8'h01, 8'hFE};
    if4.cfg_mode = 2'd3;
    if4.cfg_load = 1'b1;
    cyc(1);
    if4.cfg_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_tick(0, 8, n, ok);
      checks++;
      if (!ok || if4.led_display !== seq[i] || if4.debug_led !== ~seq[i]) begin
        errors++; $display("FAIL blink_step%0d: got tick=%b led=%h dbg=%h expected 1 %h %h",
                           i, ok, if4.led_display, if4.debug_led, seq[i], ~seq[i]);
      end
    end
    cyc(1);
    checks++;
    if (if4.status_led !== 8'h03) begin
      errors++; $display("FAIL blink_status: got %h expected 03", if4.status_led);
    end
  endtask

  task automatic test_speed();
    logic [7:0] last;
    int n;
    bit ok;
    wait_tick(1, 16, n, ok);
    wait_tick(1, 16, n, ok);
    checks++;
    if (!ok || n !== 8) begin
      errors++; $display("FAIL speed0_period: got tick=%b wait=%0d expected 1 8", ok, n);
    end
    last = if8.led_display;
    if8.cfg_mode  = 2'd0;
    if8.cfg_speed = 2'd2;
    if8.cfg_load  = 1'b1;
    cyc(1);
    if8.cfg_load  = 1'b0;
    wait_tick(1, 16, n, ok);
    checks++;
    if (!ok || n !== 7 || if8.led_display !== rotl8(last)) begin
      errors++; $display("FAIL speed_apply: got tick=%b wait=%0d led=%h expected 1 7 %h",
                         ok, n, if8.led_display, rotl8(last));
    end
    for (int i = 0; i < 3; i++) begin
      last = if8.led_display;
      wait_tick(1, 16, n, ok);
      checks++;
      if (!ok || n !== 2 || if8.led_display !== rotl8(last)) begin
        errors++; $display("FAIL speed2_step%0d: got tick=%b wait=%0d led=%h expected 1 2 %h",
                           i, ok, n, if8.led_display, rotl8(last));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    if4.cfg_mode = '0; if4.cfg_speed = '0; if4.cfg_load = 1'b0; if4.pause = 1'b0; if4.step = 1'b0;
    if8.cfg_mode = '0; if8.cfg_speed = '0; if8.cfg_load = 1'b0; if8.pause = 1'b0; if8.step = 1'b0;
    test_reset();
    test_rotl();
    test_bounce();
    test_reset_mid();
    test_pause();
    test_blink();
    test_speed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
